fifo_read_packer: RTL

- Read-side companion to the team's 8-bit synchronous FIFO.
- Drains bytes from the FIFO pop interface and packs PACK consecutive bytes into one wide word.
- Presents each word on a valid/ready output stream.
- A flush request emits a partial word, with byte-keep mask and last flag, so a downstream 32-bit consumer can take short packets.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_read_packer.sv | 117 +++++++++++
 2 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-bit synchronous FIFO and its read-side packer.
//   FIFO_DATA_WIDTH : default lane width, common to the FIFO and the packer
//   PACK_DEFAULT    : default number of lanes per packed output word
//   pack_state_t    : packer state (FILL collects bytes, HOLD presents a word)
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int PACK_DEFAULT    = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

endpackage

// File: rtl/fifo_read_packer.sv
// Drains a show-ahead FIFO one entry per cycle and packs PACK consecutive
// entries into one wide word presented on a valid/ready stream. A flush
// closes a partially filled word early, marking live lanes in out_keep and
// setting out_last.
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   fifo_rd_en   : pop request (only asserted when fifo_empty=0)
//   fifo_data    : FIFO head entry (show-ahead)
//   fifo_empty   : FIFO empty flag
//   flush        : single-cycle request to emit the buffered partial word
//   out_valid    : packed word valid
//   out_ready    : downstream accept
//   out_data     : packed word, lane 0 (LSBs) = first entry popped
//   out_keep     : per-lane valid mask
//   out_last     : word was closed by a flush
module fifo_read_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int PACK       = PACK_DEFAULT,
  parameter int CNT_W      = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  input  logic                       fifo_empty,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PACK*DATA_WIDTH-1:0] out_data,
  output logic [PACK-1:0]            out_keep,
  output logic                       out_last
);

  pack_state_t                      state;
  logic [CNT_W-1:0]                 byte_cnt;
  logic                             flush_pending;
  logic [PACK-1:0][DATA_WIDTH-1:0]  lanes;
  logic                             flush_req;
  logic                             last_lane;

  // Mask with the lowest n lanes set, i.e. (1 << n) - 1.
  function automatic logic [PACK-1:0] keep_mask(input logic [CNT_W-1:0] n);
    logic [PACK-1:0] m;
    m = '0;
    for (int i = 0; i < PACK; i++) begin
      if (CNT_W'(i) < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  // A flush captured while a word was held is serviced on the next FILL cycle.
  assign flush_req = flush | flush_pending;
  assign last_lane = (byte_cnt == CNT_W'(PACK - 1));

  // Flush takes priority over popping, so a pending flush never races a pop.
  // Reset gates the pop request directly because this path is combinational.
  assign fifo_rd_en = !reset && (state == FILL) && !flush_req && !fifo_empty;

  // Lanes not yet written stay zero because they are cleared on every accept.
  assign out_data = lanes;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FILL;
      byte_cnt      <= '0;
      flush_pending <= 1'b0;
      lanes         <= '0;
      out_valid     <= 1'b0;
      out_keep      <= '0;
      out_last      <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (flush_req) begin
            flush_pending <= 1'b0;
            // An empty buffer has nothing to close; the flush is dropped.
            if (byte_cnt != '0) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_keep  <= keep_mask(byte_cnt);
              out_last  <= 1'b1;
              byte_cnt  <= '0;
            end
          end else if (!fifo_empty) begin
            for (int i = 0; i < PACK; i++) begin
              if (byte_cnt == CNT_W'(i)) lanes[i] <= fifo_data;
            end
            if (last_lane) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_keep  <= '1;
              out_last  <= 1'b0;
              byte_cnt  <= '0;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (flush) flush_pending <= 1'b1;
          if (out_ready) begin
            state     <= FILL;
            out_valid <= 1'b0;
            lanes     <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
